// File: rtl/fir_lane_serializer.sv
// Re-serializes up to three parallel FIR lane samples per cycle into one
// ordered valid/ready stream through a small FIFO of 3-lane groups.
module fir_lane_serializer #(
  parameter int unsigned NB    = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] din0,
  input  logic [NB-1:0] din1,
  input  logic [NB-1:0] din2,
  input  logic          vin0,
  input  logic          vin1,
  input  logic          vin2,
  input  logic          rdy,
  output logic [NB-1:0] dout,
  output logic          vout,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [NB-1:0] d2;
    logic [NB-1:0] d1;
    logic [NB-1:0] d0;
    logic [2:0]    mask;
  } group_t;

  typedef enum logic {IDLE, EMIT} state_t;

  group_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  state_t        state, state_nxt;
  logic [1:0]    lane, lane_nxt;
  logic [NB-1:0] dout_nxt;
  logic          vout_nxt;
  logic          push_req, push_acc, pop, xfer;
  logic          has_next;
  logic [1:0]    next_idx;
  group_t        in_grp, head, nxt_grp;

  // Lowest valid lane of a group (mask is never 000 for stored groups).
  function automatic logic [1:0] first_lane(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  // Sample of the given lane of a group.
  function automatic logic [NB-1:0] lane_sel(input group_t g, input logic [1:0] l);
    case (l)
      2'd0:    return g.d0;
      2'd1:    return g.d1;
      default: return g.d2;
    endcase
  endfunction

  assign in_grp   = {din2, din1, din0, vin2, vin1, vin0};
  assign push_req = |in_grp.mask;
  assign head     = mem[rd_ptr];
  assign nxt_grp  = mem[rd_ptr + AW'(1)];
  assign xfer     = vout & rdy;
  assign push_acc = push_req & ((count != CW'(DEPTH)) | pop);

  // Next valid lane of the head group after the one currently presented.
  assign has_next = ((lane == 2'd0) & (head.mask[1] | head.mask[2])) |
                    ((lane == 2'd1) & head.mask[2]);
  assign next_idx = ((lane == 2'd0) & head.mask[1]) ? 2'd1 : 2'd2;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, output-register inputs and pop decision.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    dout_nxt  = dout;
    vout_nxt  = vout;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        vout_nxt = 1'b0;
        if (count != CW'(0)) begin
          lane_nxt  = first_lane(head.mask);
          dout_nxt  = lane_sel(head, lane_nxt);
          vout_nxt  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (has_next) begin
            lane_nxt = next_idx;
            dout_nxt = lane_sel(head, next_idx);
          end else begin
            pop = 1'b1;
            if (count > CW'(1)) begin
              lane_nxt = first_lane(nxt_grp.mask);
              dout_nxt = lane_sel(nxt_grp, lane_nxt);
            end else if (push_req) begin
              // Group arriving this edge becomes the new head: forward it
              // directly so full-rate streams have no bubble.
              lane_nxt = first_lane(in_grp.mask);
              dout_nxt = lane_sel(in_grp, lane_nxt);
            end else begin
              vout_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        vout_nxt  = 1'b0;
      end
    endcase
  end

  // Occupancy update.
  always_comb begin
    count_nxt = count;
    case ({push_acc, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Group storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= in_grp;
  end

  // Pointers, flags and registered serial output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
      lane   <= 2'd0;
      dout   <= '0;
      vout   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      if (push_req && !push_acc) ovf <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == CW'(0));
      lane  <= lane_nxt;
      dout  <= dout_nxt;
      vout  <= vout_nxt;
    end
  end

endmodule
